// File: rtl/feature_sum.sv
// Windowed five-stage summer: snapshots a valid window and accumulates it with one adder over five cycles.
// Optional threshold detection is built when FEATURE_SUM_THRESH_EN is defined.
module feature_sum #(
    parameter int unsigned input_width = 37,
    parameter int unsigned sum_width   = input_width + 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        data_valid,
    input  logic signed [input_width-1:0] din_stage1,
    input  logic signed [input_width-1:0] din_stage2,
    input  logic signed [input_width-1:0] din_stage3,
    input  logic signed [input_width-1:0] din_stage4,
    input  logic signed [input_width-1:0] din_stage5,
    input  logic signed [sum_width-1:0]   threshold,
    output logic signed [sum_width-1:0]   sum_out,
    output logic                        sum_ready,
    output logic                        busy,
    output logic                        overrun,
    output logic                        detect
);

    localparam int unsigned idx_width = 3;
    localparam int unsigned num_stages = 5;
    localparam logic [0:0] st_idle  = 1'b0;
    localparam logic [0:0] st_accum = 1'b1;

    logic [0:0]                   state_q, state_d;
    logic [idx_width-1:0]         idx_q, idx_d;
    logic signed [sum_width-1:0]  acc_q, acc_d;
    logic signed [input_width-1:0] snap_q [num_stages];
    logic signed [input_width-1:0] snap_d [num_stages];
    logic                         prev_valid_q, prev_valid_d;
    logic signed [sum_width-1:0]  sum_q, sum_d;
    logic                         ready_q, ready_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;
    logic                         detect_q, detect_d;
    logic signed [sum_width-1:0]  addend;
    logic signed [sum_width-1:0]  acc_sum;
    logic                         start;

`ifdef FEATURE_SUM_THRESH_EN
    logic signed [sum_width-1:0]  thr_q, thr_d;
`else
    logic                         unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    assign addend  = sum_width'(snap_q[idx_q]);
    assign acc_sum = acc_q + addend;
    assign start   = data_valid & ~prev_valid_q;

    // Next-state and datapath; only applied on enabled edges.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        snap_d       = snap_q;
        prev_valid_d = data_valid;
        sum_d        = sum_q;
        ready_d      = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        detect_d     = detect_q;
`ifdef FEATURE_SUM_THRESH_EN
        thr_d        = thr_q;
`else
        detect_d     = 1'b0;
`endif
        case (state_q)
            st_idle: begin
                if (start) begin
                    snap_d[0] = din_stage1;
                    snap_d[1] = din_stage2;
                    snap_d[2] = din_stage3;
                    snap_d[3] = din_stage4;
                    snap_d[4] = din_stage5;
`ifdef FEATURE_SUM_THRESH_EN
                    thr_d     = threshold;
`endif
                    acc_d     = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = st_accum;
                end
            end
            default: begin
                // A window arriving mid-sum, including the final edge, is dropped.
                if (start) begin
                    overrun_d = 1'b1;
                end
                acc_d = acc_sum;
                idx_d = idx_q + idx_width'(1);
                if (idx_q == idx_width'(num_stages - 1)) begin
                    sum_d   = acc_sum;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = st_idle;
`ifdef FEATURE_SUM_THRESH_EN
                    detect_d = (acc_sum > thr_q);
`endif
                end
            end
        endcase
    end

    // State register; en high freezes everything, rst overrides en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= st_idle;
            idx_q        <= '0;
            acc_q        <= '0;
            for (int i = 0; i < num_stages; i++) begin
                snap_q[i] <= '0;
            end
            prev_valid_q <= 1'b0;
            sum_q        <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            detect_q     <= 1'b0;
`ifdef FEATURE_SUM_THRESH_EN
            thr_q        <= '0;
`endif
        end else if (!en) begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            snap_q       <= snap_d;
            prev_valid_q <= prev_valid_d;
            sum_q        <= sum_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            detect_q     <= detect_d;
`ifdef FEATURE_SUM_THRESH_EN
            thr_q        <= thr_d;
`endif
        end
    end

    assign sum_out   = sum_q;
    assign sum_ready = ready_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign detect    = detect_q;

endmodule

// File: tb/tb_feature_sum.sv
// Self-checking bench for feature_sum: transaction-level reference model, directed windows, then random traffic.
module tb_feature_sum;

    localparam int unsigned IW = 37;
    localparam int unsigned SW = IW + 3;
`ifdef FEATURE_SUM_THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, data_valid;
    logic signed [IW-1:0] din_stage1, din_stage2, din_stage3, din_stage4, din_stage5;
    logic signed [SW-1:0] threshold;
    logic signed [SW-1:0] sum_out;
    logic sum_ready, busy, overrun, detect;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a window is a whole-number sum captured at the start edge and due 5 enabled edges later.
    bit     m_prev, m_busy, m_ready, m_overrun, m_detect;
    int     m_left;
    longint m_pend, m_thr, m_sum;

    feature_sum dut (
        .clk(clk), .rst(rst), .en(en), .data_valid(data_valid),
        .din_stage1(din_stage1), .din_stage2(din_stage2), .din_stage3(din_stage3),
        .din_stage4(din_stage4), .din_stage5(din_stage5),
        .threshold(threshold), .sum_out(sum_out), .sum_ready(sum_ready),
        .busy(busy), .overrun(overrun), .detect(detect)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit st;
        if (rst) begin
            m_prev = 0; m_busy = 0; m_ready = 0; m_overrun = 0; m_detect = 0;
            m_left = 0; m_sum = 0;
        end else if (!en) begin
            st     = data_valid && !m_prev;
            m_prev = data_valid;
            m_ready = 0;
            if (m_busy) begin
                if (st) m_overrun = 1;
                m_left--;
                if (m_left == 0) begin
                    m_sum    = m_pend;
                    m_ready  = 1;
                    m_busy   = 0;
                    m_detect = THR_EN ? (m_pend > m_thr) : 1'b0;
                end
            end else if (st) begin
                m_pend = longint'(din_stage1) + longint'(din_stage2) + longint'(din_stage3)
                       + longint'(din_stage4) + longint'(din_stage5);
                m_thr  = longint'(threshold);
                m_busy = 1;
                m_left = 5;
            end
        end
    endtask

    // One clock: update model on the edge, compare every output 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sum_out",   longint'(sum_out),   m_sum);
        check("sum_ready", longint'(sum_ready), longint'(m_ready));
        check("busy",      longint'(busy),      longint'(m_busy));
        check("overrun",   longint'(overrun),   longint'(m_overrun));
        check("detect",    longint'(detect),    longint'(m_detect));
    endtask

    task automatic set_stages(input longint a, input longint b, input longint c,
                              input longint d, input longint e);
        din_stage1 = IW'(a); din_stage2 = IW'(b); din_stage3 = IW'(c);
        din_stage4 = IW'(d); din_stage5 = IW'(e);
    endtask

    // Steps until sum_ready (bounded) and checks how many edges it took.
    task automatic wait_ready(input string name, input int exp_lat);
        int  n = 0;
        bit  seen = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            seen = sum_ready;
        end
        check(name, longint'(n), longint'(exp_lat));
    endtask

    function automatic logic signed [IW-1:0] rnd_stage();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return IW'(r);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; data_valid = 1'b0; threshold = '0;
        set_stages(0, 0, 0, 0, 0);

        // Reset held with data_valid toggling: everything stays zero.
        for (int i = 0; i < 4; i++) begin
            data_valid = i[0];
            step();
        end
        check("rst_sum_zero", longint'(sum_out), 0);
        rst = 1'b0; data_valid = 1'b0;
        repeat (3) step();
        check("idle_no_ready", longint'(sum_ready), 0);

        // Window 1..5, with a second rising edge two edges after capture.
        set_stages(1, 2, 3, 4, 5); threshold = SW'(14); data_valid = 1'b1;
        step();
        check("busy_after_capture", longint'(busy), 1);
        data_valid = 1'b0;
        step();
        set_stages(100, 100, 100, 100, 100); data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step();
        step();
        check("sum15_value", longint'(sum_out), 15);
        check("sum15_ready", longint'(sum_ready), 1);
        check("sum15_detect", longint'(detect), longint'(THR_EN));
        check("overrun_sticky", longint'(overrun), 1);
        step();
        check("ready_one_cycle", longint'(sum_ready), 0);
        check("idle_after_result", longint'(busy), 0);
        repeat (3) step();
        check("overrun_held", longint'(overrun), 1);
        check("no_second_result", longint'(sum_out), 15);
        rst = 1'b1; step(); rst = 1'b0;
        check("overrun_cleared", longint'(overrun), 0);

        // Sum equals threshold: no detection.
        set_stages(2, 3, 4, 5, 0); threshold = SW'(14); data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_ready("lat_sum14", 5);
        check("sum14_value", longint'(sum_out), 14);
        check("sum14_detect", longint'(detect), 0);
        step();

        // All stages at the most negative 37-bit value.
        set_stages(-(64'sd1 <<< 36), -(64'sd1 <<< 36), -(64'sd1 <<< 36),
                   -(64'sd1 <<< 36), -(64'sd1 <<< 36));
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_ready("lat_maxneg", 5);
        check("maxneg_value", longint'(sum_out), -64'sd343597383680);
        step();

        // Enable deasserted for three edges mid-sum stretches latency by three.
        set_stages(7, -3, 11, 0, 9); data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step();
        en = 1'b1;
        repeat (3) step();
        check("stall_busy_held", longint'(busy), 1);
        en = 1'b0;
        wait_ready("lat_after_stall", 3);
        check("stall_value", longint'(sum_out), 24);
        step();

        // Reset mid-sum aborts the window.
        set_stages(10, 10, 10, 10, 10); data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (8) step();
        check("abort_sum_zero", longint'(sum_out), 0);
        check("abort_not_busy", longint'(busy), 0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) data_valid = ~data_valid;
            din_stage1 = rnd_stage(); din_stage2 = rnd_stage(); din_stage3 = rnd_stage();
            din_stage4 = rnd_stage(); din_stage5 = rnd_stage();
            threshold  = SW'(rnd_stage());
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/feature_sum.md
# feature_sum

Downstream consumer of the five-stage output shift register in the feature pipeline. On each new valid window it snapshots the five stage values, sums them sequentially with one adder over five cycles, and presents a registered signed window sum with a one-cycle ready pulse. An optional threshold comparator produces the per-window detection flag.

## Interface
- `input_width`, 37, width of each signed stage value (matches the shift register output width).
- `sum_width`, `input_width+3`, width of the signed sum and threshold; must be ≥ `input_width+3`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  active-low enable; high freezes all state, including the edge detector.
- `data_valid`  in  1  level from the shift register; high while the five stages form a complete window.
- `din_stage1`..`din_stage5`  in  `input_width` each  signed stage values; stage1 is the newest.
- `threshold`  in  `sum_width`  signed detection threshold, sampled at capture.
- `sum_out`  out  `sum_width`  signed registered window sum.
- `sum_ready`  out  1  one-cycle pulse when `sum_out` updates.
- `busy`  out  1  high while a window is being summed.
- `overrun`  out  1  sticky; a window arrived while busy.
- `detect`  out  1  registered threshold result for the last window.

## Operation
- Edge detector: `prev_valid` is registered each enabled cycle. Start condition is `data_valid & ~prev_valid` (rising edge) with `en` low.
- Two-state FSM.
  - IDLE: on start, latch `din_stage1..5` into snapshot registers and `threshold` into a threshold register. Clear the accumulator and set index to 0. Go to ACCUM.
  - ACCUM: each enabled cycle, add the snapshot at the current index (sign-extended to `sum_width`) to the accumulator, then increment the index.
  - Index 4 is the last add: `sum_out` gets the final sum, `sum_ready` goes high, `detect` is updated, and the FSM returns to IDLE.
- Arithmetic: all operands sign-extended; the sum of five `input_width` values fits in `input_width+3`, so no overflow or saturation logic.
- Snapshot isolation: stage inputs changing after capture do not affect the in-flight sum.
- Start while in ACCUM: the window is dropped, `overrun` is set, and the in-flight sum completes unaffected.
- Start on the same edge the FSM returns to IDLE: dropped as busy, `overrun` set.
- `en` high: no state changes (FSM, index, accumulator, `prev_valid`, outputs hold). `sum_ready`, if high, holds until the next enabled edge.
- `rst`: dominates `en`. It aborts any in-flight sum and clears `overrun`.

## Timing
- Reset values: FSM IDLE, index 0, accumulator 0, `prev_valid` 0, `sum_out` 0, `sum_ready` 0, `busy` 0, `overrun` 0, `detect` 0.
- Capture edge E0: `busy` rises after E0.
- Adds occur at edges E1..E5. At E5: `sum_out`/`detect` update, `sum_ready` = 1, `busy` = 0.
- At E6: `sum_ready` = 0.
- Latency: 5 enabled cycles from capture to result. Throughput: one window per 6 enabled cycles minimum.
- `data_valid` held high for many cycles yields exactly one capture.
- `sum_out` and `detect` hold between results.

## Configuration
- Macro: `FEATURE_SUM_THRESH_EN`.
- Defined: threshold register and signed comparator are built; at E5, `detect` = (final sum > captured threshold).
- Undefined: no threshold register or comparator; `threshold` is ignored and `detect` is constant 0. All other behaviour is identical.

## Test plan
- Reset, then hold `rst` high with `data_valid` toggling -> all outputs stay 0. Release -> no `sum_ready` until a `data_valid` rising edge.
- Stages 1,2,3,4,5 with a rising `data_valid` -> `sum_out` = 15 and `sum_ready` one cycle, exactly 5 cycles after capture. `busy` is high for cycles 1..5.
- Stages all = −2^36 (max negative, 37-bit) -> `sum_out` = −5·2^36 exactly, sign-correct at 40 bits.
- Second `data_valid` rising edge 2 cycles after the first capture, with stages changed to 100 -> first result unchanged (15), no second `sum_ready`, `overrun` = 1 until reset.
- `en` high for 3 cycles mid-ACCUM -> `sum_ready` arrives 3 cycles later with the correct sum. `rst` pulse mid-ACCUM -> no `sum_ready`, outputs 0.
- With `FEATURE_SUM_THRESH_EN`, threshold = 14: sum 15 -> `detect` = 1; then sum 14 -> `detect` = 0. Without the macro, `detect` stays 0 for both.
